// File: rtl/key_pkg.sv
// Shared definitions for the key handling blocks: gesture FSM states,
// the active level of the key and the millisecond divider helper.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } key_state_t;

    localparam logic KEY_PRESSED = 1'b0;

    function automatic int ms_cycles(input int freq);
        return freq / 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: one-cycle tick on the terminal count of a clock
// divider that restarts whenever clr is asserted.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic tick
);

    localparam int CYCLES = ms_cycles(CLK_FREQ_HZ);
    localparam int DIV_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CYCLES - 1);

    if (CYCLES < 1) begin : g_bad_freq
        $fatal(1, "ms_tick_gen: CLK_FREQ_HZ must be at least 1000");
    end

    logic [DIV_W-1:0] div;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div <= '0;
        end else if (clr || div == LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign tick = (div == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into short press, double click,
// long press and auto-repeat pulses, all registered and one cycle wide.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LONG_MS     = 1000,
    parameter int DOUBLE_MS   = 300,
    parameter int REPEAT_MS   = 200
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_value,
    input  logic key_flag,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_press,
    output logic busy
);

    localparam int MAX_LD = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
    localparam int MAX_MS = (MAX_LD > REPEAT_MS) ? MAX_LD : REPEAT_MS;
    localparam int CNT_W  = (MAX_MS > 0) ? $clog2(MAX_MS + 1) : 1;

    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_T = CNT_W'(DOUBLE_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_MS - 1);

    if (LONG_MS < 1 || DOUBLE_MS < 1 || REPEAT_MS < 1) begin : g_bad_ms
        $fatal(1, "key_event_decoder: LONG_MS, DOUBLE_MS and REPEAT_MS must be nonzero");
    end

    key_state_t       state;
    logic [CNT_W-1:0] ms_cnt;
    logic             tick;
    logic             restart;
    logic             press_ev;
    logic             release_ev;
    logic             to_long;
    logic             to_double;
    logic             to_repeat;

    assign press_ev   = key_flag & (key_value == KEY_PRESSED);
    assign release_ev = key_flag & (key_value != KEY_PRESSED);
    assign to_long    = tick && (ms_cnt == LONG_T);
    assign to_double  = tick && (ms_cnt == DOUBLE_T);
    assign to_repeat  = tick && (ms_cnt == REPEAT_T);
    assign busy       = (state != IDLE);

    // Any state change (or a repeat in HOLD) restarts the timebase so each
    // duration is measured from the cycle after the triggering event.
    always_comb begin
        restart = 1'b0;
        unique case (state)
            IDLE:    restart = press_ev;
            PRESS1:  restart = release_ev | to_long;
            WAIT2:   restart = press_ev | to_double;
            PRESS2:  restart = release_ev | to_long;
            HOLD:    restart = release_ev | to_repeat;
            default: restart = 1'b1;
        endcase
    end

    ms_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clr    (restart),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ms_cnt <= '0;
        end else if (restart) begin
            ms_cnt <= '0;
        end else if (tick && ms_cnt != {CNT_W{1'b1}}) begin
            ms_cnt <= ms_cnt + CNT_W'(1);
        end
    end

    // Events are tested before timeouts so a coincident event suppresses the pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (press_ev) state <= PRESS1;
                end
                PRESS1: begin
                    if (release_ev) begin
                        state <= WAIT2;
                    end else if (to_long) begin
                        long_press <= 1'b1;
                        state      <= HOLD;
                    end
                end
                WAIT2: begin
                    if (press_ev) begin
                        state <= PRESS2;
                    end else if (to_double) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                    end
                end
                PRESS2: begin
                    if (release_ev) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end else if (to_long) begin
                        double_click <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (release_ev) begin
                        state <= IDLE;
                    end else if (to_repeat) begin
                        repeat_press <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed gestures plus a long
// randomized run, compared every cycle against a cycle-counting gesture model.
module tb_key_event_decoder;

    localparam int CLK_FREQ_HZ = 10_000;
    localparam int LONG_MS     = 20;
    localparam int DOUBLE_MS   = 10;
    localparam int REPEAT_MS   = 5;
    localparam int CPM         = CLK_FREQ_HZ / 1000;

    localparam int M_IDLE   = 0;
    localparam int M_PRESS1 = 1;
    localparam int M_WAIT2  = 2;
    localparam int M_PRESS2 = 3;
    localparam int M_HOLD   = 4;

    localparam int EV_SHORT  = 1;
    localparam int EV_DOUBLE = 2;
    localparam int EV_LONG   = 3;
    localparam int EV_REPEAT = 4;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic key_value;
    logic key_flag;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_press;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc;
    int pulseLog[$];
    int mState;
    int mElapsed;
    logic [4:0] mOut;
    logic level;

    key_event_decoder #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .LONG_MS    (LONG_MS),
        .DOUBLE_MS  (DOUBLE_MS),
        .REPEAT_MS  (REPEAT_MS)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_value   (key_value),
        .key_flag    (key_flag),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int code(input int ev, input int c);
        return ev * 100000 + c;
    endfunction

    function automatic int outVec();
        return int'({short_press, double_click, long_press, repeat_press, busy});
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gesture model: tracks how many cycles the current phase has lasted and
    // fires a timeout when that reaches the threshold in cycles.
    task automatic modelStep(input logic f, input logic v);
        logic press;
        logic rel;
        int nxt;
        bit again;
        logic [3:0] p;
        press = f && !v;
        rel   = f && v;
        mElapsed++;
        nxt   = mState;
        again = 1'b0;
        p     = 4'b0000;
        case (mState)
            M_IDLE: if (press) nxt = M_PRESS1;
            M_PRESS1: begin
                if (rel) nxt = M_WAIT2;
                else if (mElapsed == LONG_MS * CPM) begin p = 4'b0010; nxt = M_HOLD; end
            end
            M_WAIT2: begin
                if (press) nxt = M_PRESS2;
                else if (mElapsed == DOUBLE_MS * CPM) begin p = 4'b1000; nxt = M_IDLE; end
            end
            M_PRESS2: begin
                if (rel) begin p = 4'b0100; nxt = M_IDLE; end
                else if (mElapsed == LONG_MS * CPM) begin p = 4'b0100; nxt = M_HOLD; end
            end
            M_HOLD: begin
                if (rel) nxt = M_IDLE;
                else if (mElapsed == REPEAT_MS * CPM) begin p = 4'b0001; again = 1'b1; end
            end
            default: nxt = M_IDLE;
        endcase
        if (nxt != mState || again) mElapsed = 0;
        mState = nxt;
        mOut   = {p, nxt != M_IDLE};
    endtask

    // Drive one cycle of inputs, then compare the registered outputs after the edge.
    task automatic applyStimulus(input logic f, input logic v);
        key_flag  = f;
        key_value = v;
        @(posedge sys_clk);
        #1;
        modelStep(f, v);
        checkOutput($sformatf("outputs@%0d", cyc + 1), outVec(), int'(mOut));
        if (short_press)  pulseLog.push_back(code(EV_SHORT, cyc + 1));
        if (double_click) pulseLog.push_back(code(EV_DOUBLE, cyc + 1));
        if (long_press)   pulseLog.push_back(code(EV_LONG, cyc + 1));
        if (repeat_press) pulseLog.push_back(code(EV_REPEAT, cyc + 1));
        cyc++;
    endtask

    task automatic idleTo(input int t);
        while (cyc < t) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic pressAt(input int t);
        idleTo(t);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic releaseAt(input int t);
        idleTo(t);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic doReset();
        key_flag = 1'b0;
        sys_rst  = 1'b1;
        #1;
        checkOutput("reset_async", outVec(), 0);
        @(posedge sys_clk);
        #1;
        sys_rst  = 1'b0;
        mState   = M_IDLE;
        mElapsed = 0;
        cyc++;
        checkOutput("reset_release", outVec(), 0);
    endtask

    task automatic startScenario();
        repeat (300) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        cyc = 0;
        pulseLog.delete();
    endtask

    task automatic expectLog(input string name, input int exp[$]);
        checkOutput({name, "_count"}, pulseLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulseLog.size(); i++)
            checkOutput($sformatf("%s_%0d", name, i), pulseLog[i], exp[i]);
    endtask

    initial begin
        int e[$];
        int gap;
        sys_rst   = 1'b1;
        key_flag  = 1'b0;
        key_value = 1'b1;
        cyc       = 0;
        mState    = M_IDLE;
        mElapsed  = 0;
        level     = 1'b1;
        #1;
        checkOutput("reset_state", outVec(), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Short press
        startScenario();
        pressAt(0); releaseAt(50); idleTo(260);
        e = '{code(EV_SHORT, 151)};
        expectLog("short", e);

        // Double click
        startScenario();
        pressAt(0); releaseAt(50); pressAt(90); releaseAt(120); idleTo(260);
        e = '{code(EV_DOUBLE, 121)};
        expectLog("double", e);

        // Long press with auto-repeat
        startScenario();
        pressAt(0); releaseAt(330);
        checkOutput("busy_at_331", int'(busy), 0);
        idleTo(450);
        e = '{code(EV_LONG, 201), code(EV_REPEAT, 251), code(EV_REPEAT, 301)};
        expectLog("long", e);

        // Release lands in the same cycle as the long timeout
        startScenario();
        pressAt(0); releaseAt(200); idleTo(400);
        e = '{code(EV_SHORT, 301)};
        expectLog("tie", e);

        // Reset in the middle of a press
        startScenario();
        pressAt(0); idleTo(100); doReset(); releaseAt(150); idleTo(300);
        checkOutput("busy_after_reset", int'(busy), 0);
        e.delete();
        expectLog("reset_mid", e);
        startScenario();
        pressAt(0); releaseAt(50); idleTo(260);
        e = '{code(EV_SHORT, 151)};
        expectLog("short_after_reset", e);

        // Spurious strobes: release while idle, repeated presses while held
        startScenario();
        releaseAt(0); pressAt(20); pressAt(60); pressAt(100); pressAt(150);
        releaseAt(240); idleTo(400);
        e = '{code(EV_LONG, 221)};
        expectLog("spurious", e);

        // Randomized gestures with occasional resets and repeated levels
        for (int n = 0; n < 150; n++) begin
            gap = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 120) : $urandom_range(1, 320);
            repeat (gap) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 29) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 4) != 0) level = ~level;
                applyStimulus(1'b1, level);
            end
        end
        applyStimulus(1'b1, 1'b1);
        repeat (150) applyStimulus(1'b0, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
